alu_share_ctrl: RTL and testbench

- Two-requester controller that time-shares the single combinational ALU of the MIPS datapath, e.g. between the main execute stage and a branch/address-compare unit.
- Performs round-robin arbitration and registers the selected operands and control code onto the ALU inputs.
- Captures the ALU result and zero flag one cycle later and returns them to the winning requester with a one-cycle valid pulse.
- One operation completes every 2 cycles at most.

---
 rtl/alu_share_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Round-robin two-port arbiter in front of a shared combinational ALU.
// Registers the winning operands onto the ALU, then returns result/zero to that port.
module alu_share_ctrl #(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      CTR_W    = 4,
   parameter logic [CTR_W-1:0] SUB_CODE = CTR_W'(4'b0110)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] b1,
   input  logic [CTR_W-1:0] ctr0,
   input  logic [CTR_W-1:0] ctr1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             rvalid0,
   output logic             rvalid1,
   output logic [WIDTH-1:0] res0,
   output logic [WIDTH-1:0] res1,
   output logic             zero0,
   output logic             zero1,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [CTR_W-1:0] alu_ctr,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_zero,
   output logic             busy
);

   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   state_t           state, state_d;
   logic             last, last_d;
   logic             tag, tag_d;
   logic             win_c;
   logic             gnt0_d, gnt1_d, rvalid0_d, rvalid1_d;
   logic             zero0_d, zero1_d, zflag_c;
   logic [WIDTH-1:0] res0_d, res1_d, alu_in1_d, alu_in2_d;
   logic [CTR_W-1:0] alu_ctr_d;

   // Next-state and next-output logic
   always_comb begin
      state_d   = state;
      last_d    = last;
      tag_d     = tag;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      res0_d    = res0;
      res1_d    = res1;
      zero0_d   = zero0;
      zero1_d   = zero1;
      alu_in1_d = alu_in1;
      alu_in2_d = alu_in2;
      alu_ctr_d = alu_ctr;
      // On a tie the port that did not win last time goes next
      win_c     = (req0 && req1) ? ~last : req1;
      zflag_c   = (alu_ctr == SUB_CODE) ? alu_zero : 1'b0;

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               alu_in1_d = win_c ? a1 : a0;
               alu_in2_d = win_c ? b1 : b0;
               alu_ctr_d = win_c ? ctr1 : ctr0;
               tag_d     = win_c;
               gnt0_d    = ~win_c;
               gnt1_d    = win_c;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            if (tag) begin
               res1_d    = alu_res;
               zero1_d   = zflag_c;
               rvalid1_d = 1'b1;
            end else begin
               res0_d    = alu_res;
               zero0_d   = zflag_c;
               rvalid0_d = 1'b1;
            end
            last_d  = tag;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         last    <= 1'b1;
         tag     <= 1'b0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         res0    <= '0;
         res1    <= '0;
         zero0   <= 1'b0;
         zero1   <= 1'b0;
         alu_in1 <= '0;
         alu_in2 <= '0;
         alu_ctr <= '0;
         busy    <= 1'b0;
      end else begin
         state   <= state_d;
         last    <= last_d;
         tag     <= tag_d;
         gnt0    <= gnt0_d;
         gnt1    <= gnt1_d;
         rvalid0 <= rvalid0_d;
         rvalid1 <= rvalid1_d;
         res0    <= res0_d;
         res1    <= res1_d;
         zero0   <= zero0_d;
         zero1   <= zero1_d;
         alu_in1 <= alu_in1_d;
         alu_in2 <= alu_in2_d;
         alu_ctr <= alu_ctr_d;
         busy    <= (state_d == EXEC);
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: transaction-level reference model plus directed literal checks.
module tb_alu_share_ctrl;

   localparam logic [3:0] SUB = 4'b0110;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [31:0] a0, a1, b0, b1;
   logic [3:0]  ctr0, ctr1;
   logic        gnt0, gnt1, rvalid0, rvalid1, zero0, zero1, busy;
   logic [31:0] res0, res1, alu_in1, alu_in2, alu_res;
   logic [3:0]  alu_ctr;
   logic        alu_zero;
   logic        stuck;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_share_ctrl dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
      .ctr0(ctr0), .ctr1(ctr1), .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .res0(res0), .res1(res1),
      .zero0(zero0), .zero1(zero1), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_ctr(alu_ctr), .alu_res(alu_res), .alu_zero(alu_zero), .busy(busy)
   );

   // MIPS ALU; unsupported codes give 0
   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1100: return ~(a | b);
         default: return 32'd0;
      endcase
   endfunction

   always_comb begin
      alu_res  = ref_alu(alu_in1, alu_in2, alu_ctr);
      alu_zero = stuck | (alu_res == 32'd0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one in-flight operation at a time, completed the edge after its grant
   logic        e_gnt0, e_gnt1, e_rv0, e_rv1, e_z0, e_z1, e_busy;
   logic [31:0] e_res0, e_res1, e_in1, e_in2;
   logic [3:0]  e_ctr;
   bit          m_last, m_pend, m_tag;

   initial forever begin
      @(posedge clk);
      if (reset) begin
         {e_gnt0, e_gnt1, e_rv0, e_rv1, e_z0, e_z1, e_busy} = '0;
         e_res0 = 0; e_res1 = 0; e_in1 = 0; e_in2 = 0; e_ctr = 0;
         m_last = 1'b1; m_pend = 1'b0; m_tag = 1'b0;
      end else begin
         logic [31:0] r;
         logic        z;
         e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0;
         if (m_pend) begin
            r = ref_alu(e_in1, e_in2, e_ctr);
            z = (e_ctr == SUB) ? (stuck || r == 32'd0) : 1'b0;
            if (m_tag) begin e_res1 = r; e_z1 = z; e_rv1 = 1; end
            else       begin e_res0 = r; e_z0 = z; e_rv0 = 1; end
            m_last = m_tag;
            m_pend = 0;
         end else if (req0 || req1) begin
            m_tag  = (req0 && req1) ? !m_last : bit'(req1);
            e_in1  = m_tag ? a1 : a0;
            e_in2  = m_tag ? b1 : b0;
            e_ctr  = m_tag ? ctr1 : ctr0;
            e_gnt0 = !m_tag;
            e_gnt1 = m_tag;
            m_pend = 1;
         end
         e_busy = m_pend;
      end
   end

   // Compare every output against the model each cycle
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("gnt0", 32'(gnt0), 32'(e_gnt0));
         chk("gnt1", 32'(gnt1), 32'(e_gnt1));
         chk("rvalid0", 32'(rvalid0), 32'(e_rv0));
         chk("rvalid1", 32'(rvalid1), 32'(e_rv1));
         chk("res0", res0, e_res0);
         chk("res1", res1, e_res1);
         chk("zero0", 32'(zero0), 32'(e_z0));
         chk("zero1", 32'(zero1), 32'(e_z1));
         chk("alu_in1", alu_in1, e_in1);
         chk("alu_in2", alu_in2, e_in2);
         chk("alu_ctr", 32'(alu_ctr), 32'(e_ctr));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("gnt_overlap", 32'(gnt0 & gnt1), 32'd0);
         chk("rvalid_overlap", 32'(rvalid0 & rvalid1), 32'd0);
      end
   end

   task automatic idle_inputs();
      req0 = 0; req1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0; ctr0 = 0; ctr1 = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      @(negedge clk);
      reset = 0;
   endtask

   // Single-port op; returns at the negedge of the rvalid cycle
   task automatic op(input bit p, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] c);
      if (p) begin req1 = 1; a1 = a; b1 = b; ctr1 = c; end
      else   begin req0 = 1; a0 = a; b0 = b; ctr0 = c; end
      @(negedge clk);
      req0 = 0; req1 = 0;
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] codes [7] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'hF};
      stuck = 0;
      idle_inputs();
      reset = 1;
      @(negedge clk);
      chk_en = 1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu_in1", alu_in1, 32'd0);
      chk("rst_res0", res0, 32'd0);
      reset = 0;

      // Subtract 7-7 on port 0
      req0 = 1; a0 = 7; b0 = 7; ctr0 = SUB;
      @(negedge clk);
      req0 = 0;
      chk("t1_gnt0", 32'(gnt0), 32'd1);
      chk("t1_alu_in1", alu_in1, 32'd7);
      chk("t1_alu_ctr", 32'(alu_ctr), 32'h6);
      chk("t1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t1_rvalid0", 32'(rvalid0), 32'd1);
      chk("t1_res0", res0, 32'd0);
      chk("t1_zero0", 32'(zero0), 32'd1);
      chk("t1_res1", res1, 32'd0);
      chk("t1_rvalid1", 32'(rvalid1), 32'd0);

      // Port 1 add, subtract, stale zero on OR
      op(1, 32'd5, 32'd3, 4'b0010);
      chk("t2_res1", res1, 32'd8);
      chk("t2_zero1", 32'(zero1), 32'd0);
      op(1, 32'd4, 32'd4, SUB);
      chk("t2_sub_zero1", 32'(zero1), 32'd1);
      stuck = 1;
      op(1, 32'd0, 32'd0, 4'b0001);
      chk("t2_or_zero1", 32'(zero1), 32'd0);
      chk("t2_or_res1", res1, 32'd0);
      stuck = 0;

      // Continuous contention from reset
      do_reset();
      req0 = 1; req1 = 1; a0 = 32'd10; b0 = 32'd1; a1 = 32'd20; b1 = 32'd2;
      ctr0 = 4'b0010; ctr1 = 4'b0010;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 8) begin req0 = 0; req1 = 0; end
         chk("t3_gnt0", 32'(gnt0), 32'(k % 4 == 1));
         chk("t3_gnt1", 32'(gnt1), 32'(k % 4 == 3));
         chk("t3_rvalid0", 32'(rvalid0), 32'(k % 4 == 2));
         chk("t3_rvalid1", 32'(rvalid1), 32'(k % 4 == 0));
      end
      chk("t3_res0", res0, 32'd11);
      chk("t3_res1", res1, 32'd22);

      // Wrap-around add; operands changed after the grant
      req0 = 1; a0 = 32'hFFFF_FFFF; b0 = 32'd1; ctr0 = 4'b0010;
      @(negedge clk);
      req0 = 0; a0 = 32'd123; b0 = 32'd456;
      @(negedge clk);
      chk("t4_rvalid0", 32'(rvalid0), 32'd1);
      chk("t4_res0", res0, 32'd0);
      chk("t4_zero0", 32'(zero0), 32'd0);

      // Reset during EXEC abandons the operation
      req0 = 1; a0 = 0; b0 = 0; ctr0 = 4'b1100;
      @(negedge clk);
      req0 = 0; reset = 1;
      @(negedge clk);
      reset = 0;
      chk("t5_rvalid0", 32'(rvalid0), 32'd0);
      chk("t5_res0", res0, 32'd0);
      chk("t5_res1", res1, 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_alu_ctr", 32'(alu_ctr), 32'd0);
      req0 = 1; req1 = 1;
      @(negedge clk);
      req0 = 0; req1 = 0;
      chk("t5_tie_gnt0", 32'(gnt0), 32'd1);
      chk("t5_tie_gnt1", 32'(gnt1), 32'd0);
      @(negedge clk);

      // Unsupported control code
      op(0, 32'd9, 32'd9, 4'b1111);
      chk("t6_rvalid0", 32'(rvalid0), 32'd1);
      chk("t6_res0", res0, 32'd0);
      chk("t6_zero0", 32'(zero0), 32'd0);
      @(negedge clk);
      chk("t6_rvalid0_once", 32'(rvalid0), 32'd0);

      // Randomized traffic checked by the model
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 63) == 0);
         req0  = 1'($urandom_range(0, 1));
         req1  = 1'($urandom_range(0, 1));
         a0 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
         b0 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
         a1 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
         b1 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
         ctr0 = codes[$urandom_range(0, 6)];
         ctr1 = codes[$urandom_range(0, 6)];
         stuck = ($urandom_range(0, 7) == 0);
         @(negedge clk);
      end
      reset = 0; stuck = 0;
      idle_inputs();
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
